serial_adder_n: RTL and testbench
=================================

// Module: serial_adder_n
// PURPOSE
//  Parametrised bit-serial adder/subtractor; multi-cycle successor to the combinational half adder.
//  Adds or subtracts two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a carry flop.
//  Start/busy/done handshake.
//  Reports sum, carry-out and signed overflow.
//  Area-lean arithmetic unit for control/datapath blocks where latency is acceptable.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..64
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only when busy=0
//  sub        in   1      0: a+b, 1: a-b; sampled with start
//  a          in   WIDTH  operand A; sampled with start
//  b          in   WIDTH  operand B; sampled with start
//  busy       out  1      operation in progress
//  done       out  1      one-cycle pulse: result valid and updated
//  sum        out  WIDTH  result (a+b or a-b, mod 2^WIDTH)
//  carry_out  out  1      final carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed (two's-complement) overflow of the result
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all outputs and internal registers = 0.
//   - Any operation in flight is abandoned; no done pulse after release.
//  FSM: IDLE -> RUN -> DONE.
//   - IDLE: on a clk edge with start=1:
//     - load shift regs A<=a, B<=(sub ? ~b : b); carry flop<=sub; bit count<=0; go RUN.
//   - RUN: each edge, full add of A[0], B[0] and carry.
//     - Sum bit shifts into the result reg at the MSB end; A and B shift right.
//     - Carry flop <= cell carry-out.
//     - At count=WIDTH-1, go DONE.
//   - DONE: one cycle only.
//     - done=1 and busy=0.
//     - sum/carry_out/overflow show the new result, registered on the edge entering DONE.
//     - Next state: IDLE, or directly RUN if start=1 (back-to-back accept).
//  busy=1 exactly while state=RUN.
//   - start while busy is ignored; operands are not resampled.
//  Latency: start sampled at edge k -> done high after edge k+WIDTH, low after edge k+WIDTH+1.
//   - Throughput: one op per WIDTH+1 cycles.
//  sum, carry_out and overflow hold their value until the next DONE.
//   - The partial result is never visible on sum.
//  overflow = (carry into MSB) XOR (carry out of MSB).
//   - Carry into MSB is the carry flop value during the last RUN cycle.
//  WIDTH=1: a single RUN cycle. overflow still follows the rule above.
//  a, b and sub may change freely after the start edge without effect.
// TESTING (WIDTH=8 unless noted)
//  T1: a=0x0F, b=0x01, sub=0, start 1 cycle
//      -> busy 8 cycles, done pulse after edge k+8; sum=0x10, co=0, ov=0.
//  T2: 0xFF+0x01 -> sum=0x00, co=1, ov=0.
//      0x7F+0x01 -> sum=0x80, co=0, ov=1.
//  T3: sub: 0x05-0x07 -> sum=0xFE, co=0, ov=0.
//      0x80-0x01 -> sum=0x7F, co=1, ov=1.
//  T4: start held high 3 ops with changing operands
//      -> done every 9 cycles, each result matches operands at its accept edge; mid-run start ignored.
//  T5: rst_n=0 at RUN cycle 4
//      -> all outputs 0 immediately; no done after release; next op correct.
//  T6: WIDTH=1 and WIDTH=16, exhaustive / 1000 random ops, add and sub
//      -> sum, co, ov match the reference model; done 1 cycle after the last RUN cycle.

Source files
------------

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, accepted whenever busy=0 (IDLE or DONE)
//   sub, a, b        operation select and operands, sampled on the accept edge
//   busy             high while the serial add is running
//   done             one-cycle pulse when sum/carry_out/overflow update
//   sum              result, mod 2^WIDTH; holds until the next done
//   carry_out        carry out of the MSB (subtract: 1 = no borrow)
//   overflow         two's-complement overflow of the result
module serial_adder_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;

   logic             cell_s;
   logic             cell_co;
   logic [WIDTH-1:0] res_shift;

   // Full-adder cell on the current LSBs; new sum bit enters the result at the MSB end
   always_comb begin
      cell_s    = a_q[0] ^ b_q[0] ^ carry_q;
      cell_co   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
      res_shift = (res_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
   end

   // Control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state_q)
            // DONE behaves like IDLE for acceptance, giving back-to-back ops
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtract as a + ~b + 1: the +1 rides in on the carry flop
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               res_q   <= res_shift;
               carry_q <= cell_co;
               if (cnt_q == LAST_BIT) begin
                  // carry_q here is the carry into the MSB
                  sum       <= res_shift;
                  carry_out <= cell_co;
                  overflow  <= carry_q ^ cell_co;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH=8, 1 and 16 (three instances, one shared stimulus bus).
module tb_serial_adder_n;

   logic        clk;
   logic        rst_n;
   logic        start_r;
   logic        sub_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   int          sel;

   logic        start8, start1, start16;
   logic        busy8, done8, co8, ov8;
   logic        busy1, done1, co1, ov1;
   logic        busy16, done16, co16, ov16;
   logic [7:0]  sum8;
   logic [0:0]  sum1;
   logic [15:0] sum16;

   logic        o_busy, o_done, o_co, o_ov;
   logic [15:0] o_sum;

   int checks   = 0;
   int failures = 0;

   assign start8  = start_r && (sel == 0);
   assign start1  = start_r && (sel == 1);
   assign start16 = start_r && (sel == 2);

   serial_adder_n #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_r),
      .a(a_r[7:0]), .b(b_r[7:0]), .busy(busy8), .done(done8),
      .sum(sum8), .carry_out(co8), .overflow(ov8));

   serial_adder_n #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub_r),
      .a(a_r[0:0]), .b(b_r[0:0]), .busy(busy1), .done(done1),
      .sum(sum1), .carry_out(co1), .overflow(ov1));

   serial_adder_n #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub_r),
      .a(a_r), .b(b_r), .busy(busy16), .done(done16),
      .sum(sum16), .carry_out(co16), .overflow(ov16));

   // View of the currently selected instance
   always_comb begin
      o_busy = busy8;
      o_done = done8;
      o_co   = co8;
      o_ov   = ov8;
      o_sum  = 16'(sum8);
      if (sel == 1) begin
         o_busy = busy1; o_done = done1; o_co = co1; o_ov = ov1; o_sum = 16'(sum1);
      end else if (sel == 2) begin
         o_busy = busy16; o_done = done16; o_co = co16; o_ov = ov16; o_sum = sum16;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One operation: accept edge, latency, busy, hidden partial result, outputs, pulse width
   task automatic run_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic [15:0] es, input logic eco,
                         input logic eov, input string tag);
      int w;
      int j;
      logic [15:0] held;
      logic        hold_ok;
      w = (s == 0) ? 8 : ((s == 1) ? 1 : 16);
      @(negedge clk);
      sel = s; a_r = av; b_r = bv; sub_r = sv; start_r = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0; a_r = ~av; b_r = 16'h5A5A; sub_r = ~sv;
      chk({tag, "_busy"}, 64'(o_busy), 64'd1);
      held    = o_sum;
      hold_ok = 1'b1;
      j = 0;
      while (!o_done && j < w + 4) begin
         if (o_sum !== held) hold_ok = 1'b0;
         @(negedge clk);
         j++;
      end
      chk({tag, "_latency"}, 64'(j), 64'(w));
      chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
      chk({tag, "_sum"}, 64'(o_sum), 64'(es));
      chk({tag, "_co"}, 64'(o_co), 64'(eco));
      chk({tag, "_ov"}, 64'(o_ov), 64'(eov));
      chk({tag, "_busy_done"}, 64'(o_busy), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(o_done), 64'd0);
      chk({tag, "_keep"}, 64'(o_sum), 64'(es));
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0; start_r = 1'b0; sub_r = 1'b0; a_r = '0; b_r = '0; sel = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_sum",  64'(sum8),  64'd0);
      chk("rst_co_ov", 64'({co8, ov8}), 64'd0);
      rst_n = 1'b1;

      // WIDTH=8 single operations
      run_op(0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, "t1_0f_p_01");
      run_op(0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_ff_p_01");
      run_op(0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, "t2_7f_p_01");
      run_op(0, 16'h0005, 16'h0007, 1'b1, 16'h00FE, 1'b0, 1'b0, "t3_05_m_07");
      run_op(0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1, "t3_80_m_01");

      // Back-to-back with start held high; operands change mid-run
      @(negedge clk);
      sel = 0; start_r = 1'b1; a_r = 16'h0012; b_r = 16'h0034; sub_r = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a_r = 16'h0030; b_r = 16'h0010; sub_r = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("t4_op0_done", 64'(done8), 64'd1);
      chk("t4_op0_sum", 64'({co8, ov8, sum8}), 64'h046);
      @(posedge clk);
      @(negedge clk);
      chk("t4_op1_accept", 64'({busy8, done8}), 64'b10);
      a_r = 16'h00C0; b_r = 16'h00C0; sub_r = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("t4_op1_done", 64'(done8), 64'd1);
      chk("t4_op1_sum", 64'({co8, ov8, sum8}), 64'h220);
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0; a_r = 16'hFFFF; b_r = 16'hFFFF; sub_r = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("t4_op2_done", 64'(done8), 64'd1);
      chk("t4_op2_sum", 64'({co8, ov8, sum8}), 64'h280);
      @(negedge clk);
      chk("t4_idle", 64'({busy8, done8}), 64'd0);

      // Reset during RUN cycle 4
      @(negedge clk);
      start_r = 1'b1; a_r = 16'h000F; b_r = 16'h0001; sub_r = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_sum", 64'(sum8), 64'd0);
      chk("t5_rst_flags", 64'({busy8, done8, co8, ov8}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) done_seen++;
      end
      chk("t5_no_done", 64'(done_seen), 64'd0);
      run_op(0, 16'h0064, 16'h0032, 1'b1, 16'h0032, 1'b1, 1'b0, "t5_after");

      // WIDTH=1 exhaustive
      run_op(1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "w1_0p0");
      run_op(1, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, "w1_0p1");
      run_op(1, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, "w1_1p0");
      run_op(1, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, "w1_1p1");
      run_op(1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "w1_0m0");
      run_op(1, 16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, "w1_0m1");
      run_op(1, 16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, "w1_1m0");
      run_op(1, 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, "w1_1m1");

      // WIDTH=16 directed
      run_op(2, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "w16_add");
      run_op(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_wrap");
      run_op(2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "w16_sub_ov");
      run_op(2, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "w16_borrow");
      run_op(2, 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, "w16_add_ov");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
